// File: rtl/scene_renderer_pkg.sv
// Shared geometry defaults, colours and encodings for the scene renderer.
// Imported by the top-level FSM and the per-pixel classifier.
package scene_renderer_pkg;

  localparam int SCENE_W_D = 320;
  localparam int SCENE_H_D = 480;
  localparam int CELL_D    = 16;
  localparam int COLS_D    = SCENE_W_D / CELL_D;
  localparam int ROWS_D    = SCENE_H_D / CELL_D;

  localparam logic [23:0] WALL_RGB_D   = 24'h0010FE;
  localparam logic [23:0] FOOD_RGB_D   = 24'hFE1000;
  localparam logic [23:0] PLAYER_RGB_D = 24'h00FE00;
  localparam logic [23:0] BG_RGB_D     = 24'h000000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    CLASSIFY = 3'd2,
    SEND     = 3'd3,
    STROBE   = 3'd4,
    DONE     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PIX_BG     = 2'd0,
    PIX_FOOD   = 2'd1,
    PIX_PLAYER = 2'd2,
    PIX_WALL   = 2'd3
  } pix_class_t;

endpackage

// File: rtl/scene_renderer_cell_painter.sv
// Combinational pixel classifier: maps (x,y) plus latched maze state to a
// pixel class with priority wall > player > food > background.
module cell_painter
  import scene_renderer_pkg::*;
#(
  parameter int SCENE_W = SCENE_W_D,
  parameter int SCENE_H = SCENE_H_D,
  parameter int CELL    = CELL_D,
  parameter int COLS    = COLS_D,
  parameter int ROWS    = ROWS_D,
  parameter int WALL_T  = 2,
  parameter int FOOD_SZ = 4
) (
  input  logic [$clog2(SCENE_W)-1:0]     x,
  input  logic [$clog2(SCENE_H)-1:0]     y,
  input  logic [(ROWS+1)*COLS-1:0]       h_walls,
  input  logic [ROWS*(COLS+1)-1:0]       v_walls,
  input  logic [ROWS*COLS-1:0]           food,
  input  logic [$clog2(COLS)-1:0]        player_col,
  input  logic [$clog2(ROWS)-1:0]        player_row,
  output pix_class_t                     pix_class
);

  localparam int XW = $clog2(SCENE_W);
  localparam int YW = $clog2(SCENE_H);
  localparam int LW = $clog2(CELL);
  localparam int NH = (ROWS + 1) * COLS;
  localparam int NV = ROWS * (COLS + 1);
  localparam int NF = ROWS * COLS;

  // One extra bit so a food square touching the cell edge still compares correctly.
  localparam logic [LW:0] BAND_LO = (LW+1)'(WALL_T);
  localparam logic [LW:0] BAND_HI = (LW+1)'(CELL - WALL_T);
  localparam logic [LW:0] FOOD_LO = (LW+1)'((CELL - FOOD_SZ) / 2);
  localparam logic [LW:0] FOOD_HI = (LW+1)'((CELL + FOOD_SZ) / 2);

  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [LW:0]   lx, ly;
  logic [15:0]   h_idx, v_idx;
  logic [NH-1:0] h_top_sh, h_bot_sh;
  logic [NV-1:0] v_sh;
  logic [NF-1:0] food_sh;
  logic          band_x, band_y, is_wall, is_player, is_food;

  assign cx = x >> LW;
  assign cy = y >> LW;
  assign lx = {1'b0, x[LW-1:0]};
  assign ly = {1'b0, y[LW-1:0]};

  assign h_idx = 16'(cy) * 16'(COLS) + 16'(cx);
  assign v_idx = 16'(cy) * 16'(COLS + 1) + 16'(cx);

  // Shift-and-pick keeps the variable bit selects width-clean.
  assign h_top_sh = h_walls >> h_idx;
  assign h_bot_sh = h_walls >> (h_idx + 16'(COLS));
  assign v_sh     = v_walls >> v_idx;
  assign food_sh  = food >> h_idx;

  assign band_x = (lx < BAND_LO) || (lx >= BAND_HI);
  assign band_y = (ly < BAND_LO) || (ly >= BAND_HI);

  assign is_wall = ((ly <  BAND_LO) && h_top_sh[0]) ||
                   ((ly >= BAND_HI) && h_bot_sh[0]) ||
                   ((lx <  BAND_LO) && v_sh[0])     ||
                   ((lx >= BAND_HI) && v_sh[1]);

  assign is_player = (cx == XW'(player_col)) && (cy == YW'(player_row)) &&
                     !band_x && !band_y;

  assign is_food = food_sh[0] && (lx >= FOOD_LO) && (lx < FOOD_HI) &&
                   (ly >= FOOD_LO) && (ly < FOOD_HI);

  always_comb begin
    pix_class = PIX_BG;
    if (is_wall) begin
      pix_class = PIX_WALL;
    end else if (is_player) begin
      pix_class = PIX_PLAYER;
    end else if (is_food) begin
      pix_class = PIX_FOOD;
    end
  end

endmodule

// File: rtl/scene_renderer.sv
// Streams a rectangular window of the maze scene to a byte-wide TFT sender,
// one strobe per colour byte, in raster order, MSB byte first.
module scene_renderer
  import scene_renderer_pkg::*;
#(
  parameter int          SCENE_W    = SCENE_W_D,
  parameter int          SCENE_H    = SCENE_H_D,
  parameter int          CELL       = CELL_D,
  parameter int          COLS       = SCENE_W / CELL,
  parameter int          ROWS       = SCENE_H / CELL,
  parameter int          WALL_T     = 2,
  parameter int          FOOD_SZ    = 4,
  parameter int          BPP        = 3,
  parameter logic [23:0] WALL_RGB   = WALL_RGB_D,
  parameter logic [23:0] FOOD_RGB   = FOOD_RGB_D,
  parameter logic [23:0] PLAYER_RGB = PLAYER_RGB_D,
  parameter logic [23:0] BG_RGB     = BG_RGB_D
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(SCENE_W)-1:0]   win_x0,
  input  logic [$clog2(SCENE_W)-1:0]   win_x1,
  input  logic [$clog2(SCENE_H)-1:0]   win_y0,
  input  logic [$clog2(SCENE_H)-1:0]   win_y1,
  input  logic [(ROWS+1)*COLS-1:0]     h_walls,
  input  logic [ROWS*(COLS+1)-1:0]     v_walls,
  input  logic [ROWS*COLS-1:0]         food,
  input  logic [$clog2(COLS)-1:0]      player_col,
  input  logic [$clog2(ROWS)-1:0]      player_row,
  input  logic                         tft_busy,
  output logic                         tft_dc,
  output logic [7:0]                   tft_data,
  output logic                         tft_transmit,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int XW  = $clog2(SCENE_W);
  localparam int YW  = $clog2(SCENE_H);
  localparam int PCW = $clog2(COLS);
  localparam int PRW = $clog2(ROWS);
  localparam int NH  = (ROWS + 1) * COLS;
  localparam int NV  = ROWS * (COLS + 1);
  localparam int NF  = ROWS * COLS;
  localparam int PW  = 8 * BPP;
  localparam int BW  = $clog2(BPP + 1);

  localparam logic [XW:0]   SW_L   = (XW+1)'(SCENE_W);
  localparam logic [YW:0]   SH_L   = (YW+1)'(SCENE_H);
  localparam logic [BW-1:0] B_LAST = BW'(BPP - 1);

  state_t         state_q, state_d;
  logic [XW-1:0]  wx0_q, wx0_d, wx1_q, wx1_d, x_q, x_d;
  logic [YW-1:0]  wy0_q, wy0_d, wy1_q, wy1_d, y_q, y_d;
  logic [NH-1:0]  hw_q, hw_d;
  logic [NV-1:0]  vw_q, vw_d;
  logic [NF-1:0]  fd_q, fd_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [PRW-1:0] pr_q, pr_d;
  logic [BW-1:0]  b_q, b_d;
  logic [PW-1:0]  rgb_q, rgb_d;
  logic [7:0]     data_q, data_d;
  logic           tx_q, tx_d;
  logic           err_q, err_d;
  logic           bad_window;
  pix_class_t     pix_class;

  cell_painter #(
    .SCENE_W (SCENE_W),
    .SCENE_H (SCENE_H),
    .CELL    (CELL),
    .COLS    (COLS),
    .ROWS    (ROWS),
    .WALL_T  (WALL_T),
    .FOOD_SZ (FOOD_SZ)
  ) u_painter (
    .x          (x_q),
    .y          (y_q),
    .h_walls    (hw_q),
    .v_walls    (vw_q),
    .food       (fd_q),
    .player_col (pc_q),
    .player_row (pr_q),
    .pix_class  (pix_class)
  );

  assign bad_window = (wx0_q > wx1_q) || (wy0_q > wy1_q) ||
                      ({1'b0, wx1_q} >= SW_L) || ({1'b0, wy1_q} >= SH_L);

  always_comb begin
    state_d = state_q;
    wx0_d   = wx0_q;
    wx1_d   = wx1_q;
    wy0_d   = wy0_q;
    wy1_d   = wy1_q;
    hw_d    = hw_q;
    vw_d    = vw_q;
    fd_d    = fd_q;
    pc_d    = pc_q;
    pr_d    = pr_q;
    x_d     = x_q;
    y_d     = y_q;
    b_d     = b_q;
    rgb_d   = rgb_q;
    data_d  = data_q;
    tx_d    = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          wx0_d   = win_x0;
          wx1_d   = win_x1;
          wy0_d   = win_y0;
          wy1_d   = win_y1;
          hw_d    = h_walls;
          vw_d    = v_walls;
          fd_d    = food;
          pc_d    = player_col;
          pr_d    = player_row;
          err_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (bad_window) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          x_d     = wx0_q;
          y_d     = wy0_q;
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: begin
        case (pix_class)
          PIX_WALL:   rgb_d = PW'(WALL_RGB);
          PIX_PLAYER: rgb_d = PW'(PLAYER_RGB);
          PIX_FOOD:   rgb_d = PW'(FOOD_RGB);
          default:    rgb_d = PW'(BG_RGB);
        endcase
        b_d     = '0;
        state_d = SEND;
      end
      SEND: begin
        if (!tft_busy) begin
          data_d  = rgb_q[PW-1 -: 8];
          tx_d    = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (b_q != B_LAST) begin
          // Next byte moves into the MSB slot so SEND always reads the top byte.
          b_d     = b_q + 1'b1;
          rgb_d   = rgb_q << 8;
          state_d = SEND;
        end else if (x_q != wx1_q) begin
          x_d     = x_q + 1'b1;
          state_d = CLASSIFY;
        end else if (y_q != wy1_q) begin
          x_d     = wx0_q;
          y_d     = y_q + 1'b1;
          state_d = CLASSIFY;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wx0_q   <= '0;
      wx1_q   <= '0;
      wy0_q   <= '0;
      wy1_q   <= '0;
      hw_q    <= '0;
      vw_q    <= '0;
      fd_q    <= '0;
      pc_q    <= '0;
      pr_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      b_q     <= '0;
      rgb_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wx0_q   <= wx0_d;
      wx1_q   <= wx1_d;
      wy0_q   <= wy0_d;
      wy1_q   <= wy1_d;
      hw_q    <= hw_d;
      vw_q    <= vw_d;
      fd_q    <= fd_d;
      pc_q    <= pc_d;
      pr_q    <= pr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      b_q     <= b_d;
      rgb_q   <= rgb_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      err_q   <= err_d;
    end
  end

  assign tft_dc       = 1'b1;
  assign tft_data     = data_q;
  assign tft_transmit = tx_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign err          = err_q;

endmodule
